seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Passive monitor on the multiplexed display bus (digit-select `trans` and segment `led7seg`).
- Recovers the value shown on each digit by decoding the multiplexed segment patterns back to 4-bit hex codes.
- Used for on-board loopback self-check and bench scoreboarding of the display path. It never drives the bus.

Parameters:
- NUM_DIGITS, 7, number of digit-select lines (width of trans).
- SETTLE_CYCLES, 4, consecutive stable cycles required before a digit is captured (range 1..255).
- TRANS_ACTIVE_LOW, 1, 1 = a digit is selected when its trans bit is 0.
- SEG_ACTIVE_LOW, 1, 1 = a segment is lit when its led7seg bit is 0 (common anode).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- trans  in  NUM_DIGITS  digit-select bus being observed.
- led7seg  in  7  segment bus being observed; bit0=a … bit6=g.
- digit_vals  out  4*NUM_DIGITS  decoded hex value per digit; digit i is in bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit i has been captured since reset.
- frame_done  out  1  one-cycle pulse when every digit has been captured at least once since the previous pulse.
- pattern_err  out  1  one-cycle pulse when a settled pattern is not a legal hex glyph.
- select_err  out  1  one-cycle pulse when more than one digit is selected.

Behaviour:
- Inputs are registered once internally; all decisions use the registered copies.
- Polarity: trans and led7seg are normalised to active-high per the parameters before any decode.
- Glyph table (active-high, in {g,f,e,d,c,b,a} order):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Any other pattern is illegal.
- State machine:
  - IDLE: normalised trans is not exactly one-hot.
    - Zero bits selected: stay in IDLE.
    - Two or more bits selected: pulse select_err on entry and on each change of the multi-hot value.
    - Exactly one-hot: latch the selected index and pattern, load counter=1, go to SETTLE.
  - SETTLE:
    - Each cycle where trans and pattern both equal the latched values: counter increments.
    - When counter reaches SETTLE_CYCLES: go to CAPTURE.
    - Any change in trans or pattern: return to IDLE on the same cycle, then re-evaluate on the next cycle.
  - CAPTURE (single cycle):
    - Legal glyph: write the 4-bit code into digit_vals[idx], set digit_valid[idx] and seen[idx].
    - Illegal glyph: pulse pattern_err; digit_vals and digit_valid are unchanged.
    - Then go to HOLD.
  - HOLD: stay until trans or pattern changes, then go to IDLE. This prevents recapturing the same scan slot.
- Latency: digit_vals updates SETTLE_CYCLES+2 clocks after the pair first appears, counted from the input registration.
- frame_done:
  - Pulses on the same cycle the last unset seen bit becomes set.
  - seen is cleared that same cycle.
  - Recapture of an already-seen digit does not re-trigger it.
- Simultaneous events: select_err and pattern_err cannot coincide, since they occur in different states.
- Reset, including mid-SETTLE:
  - State returns to IDLE; counter is cleared.
  - digit_vals = 0, digit_valid = 0, seen = 0.
  - frame_done, pattern_err and select_err are all 0.
- Counter saturates; it cannot wrap in HOLD.

Optional Feature:
- Macro SEG7_BLANK_DETECT_EN.
- Defined:
  - An all-off normalised pattern is legal "blank".
  - Captures write code 4'h0 and clear digit_valid[idx].
  - Sets seen[idx].
  - Adds output port digit_blank (NUM_DIGITS bits), set for blank and cleared on any legal-glyph capture; reset value 0.
- Not defined: all-off is illegal and raises pattern_err; the port digit_blank does not exist.

Test Plan:
- Reset check: assert rst mid-SETTLE → all outputs 0 on the next clock edge; no capture afterwards.
- Basic capture (defaults): trans=7'b1111110 (digit 0), led7seg=7'b1111001 ("1") held 10 cycles → digit_vals[3:0]=4'h1, digit_valid[0]=1 at cycle 6, exactly one capture.
- Short hold: same pair held only 3 cycles → no capture, digit_valid stays 0.
- Full scan: scan digits 0..6 showing 0,1,2,3,4,5,6, 8 cycles each → digit_vals=28'h6543210, frame_done single pulse after digit 6; repeat scan → second pulse.
- Ghosting and bad glyph:
  - trans=7'b1111100 → select_err pulses once, no capture.
  - Then digit 2 with led7seg=7'b0111111 (normalised 1000000, illegal) → pattern_err pulses once, digit_vals unchanged.
- Blank (with SEG7_BLANK_DETECT_EN): digit 3 with led7seg=7'b1111111 → digit_blank[3]=1, digit_valid[3]=0; without the macro → pattern_err pulses.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Passive monitor that decodes a multiplexed 7-segment display bus back to per-digit hex codes.
// Optional SEG7_BLANK_DETECT_EN: treat an all-off pattern as a legal blank and expose digit_blank.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS       = 7,
  parameter int SETTLE_CYCLES    = 4,
  parameter int TRANS_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   trans,
  input  logic [6:0]              led7seg,
  output logic [4*NUM_DIGITS-1:0] digit_vals,
  output logic [NUM_DIGITS-1:0]   digit_valid,
`ifdef SEG7_BLANK_DETECT_EN
  output logic [NUM_DIGITS-1:0]   digit_blank,
`endif
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic                    select_err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t                  state, state_next;
  logic [NUM_DIGITS-1:0]   trans_r, trans_prev, lat_trans, seen;
  logic [6:0]              seg_r, lat_seg;
  logic [IDX_W-1:0]        lat_idx, sel_idx;
  logic [7:0]              cnt;
  logic                    one_hot, multi, multi_seen, match, sel_err_next;
  logic                    glyph_ok, glyph_blank, cap_ok, frame_hit;
  logic [3:0]              glyph_code;
  logic [NUM_DIGITS-1:0]   idx_mask, seen_upd;

  // Normalise both buses to active-high at the input register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trans_r <= '0;
      seg_r   <= '0;
    end else begin
      trans_r <= (TRANS_ACTIVE_LOW != 0) ? ~trans : trans;
      seg_r   <= (SEG_ACTIVE_LOW != 0) ? ~led7seg : led7seg;
    end
  end

  always_comb begin
    one_hot = $onehot(trans_r);
    multi   = (trans_r != '0) && !one_hot;
    match   = (trans_r == lat_trans) && (seg_r == lat_seg);
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (trans_r[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    glyph_ok   = 1'b1;
    glyph_code = 4'h0;
    case (lat_seg)
      7'b0111111: glyph_code = 4'h0;
      7'b0000110: glyph_code = 4'h1;
      7'b1011011: glyph_code = 4'h2;
      7'b1001111: glyph_code = 4'h3;
      7'b1100110: glyph_code = 4'h4;
      7'b1101101: glyph_code = 4'h5;
      7'b1111101: glyph_code = 4'h6;
      7'b0000111: glyph_code = 4'h7;
      7'b1111111: glyph_code = 4'h8;
      7'b1101111: glyph_code = 4'h9;
      7'b1110111: glyph_code = 4'hA;
      7'b1111100: glyph_code = 4'hB;
      7'b0111001: glyph_code = 4'hC;
      7'b1011110: glyph_code = 4'hD;
      7'b1111001: glyph_code = 4'hE;
      7'b1110001: glyph_code = 4'hF;
      default:    glyph_ok   = 1'b0;
    endcase
`ifdef SEG7_BLANK_DETECT_EN
    glyph_blank = (lat_seg == 7'b0000000);
`else
    glyph_blank = 1'b0;
`endif
  end

  always_comb begin
    state_next   = state;
    sel_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot) state_next = SETTLE;
        // Re-flag only on entry to a multi-hot value or when that value changes
        else if (multi && (!multi_seen || trans_r != trans_prev)) sel_err_next = 1'b1;
      end
      SETTLE: begin
        if (!match) state_next = IDLE;
        else if (cnt >= SETTLE_MAX) state_next = CAPTURE;
      end
      CAPTURE: state_next = HOLD;
      HOLD:    if (!match) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_trans  <= '0;
      lat_seg    <= '0;
      lat_idx    <= '0;
      multi_seen <= 1'b0;
      trans_prev <= '0;
    end else begin
      state      <= state_next;
      multi_seen <= (state == IDLE) && multi;
      trans_prev <= trans_r;
      case (state)
        IDLE: begin
          if (one_hot) begin
            lat_trans <= trans_r;
            lat_seg   <= seg_r;
            lat_idx   <= sel_idx;
            cnt       <= 8'd1;
          end else begin
            cnt <= '0;
          end
        end
        SETTLE:  if (match && cnt < SETTLE_MAX) cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    cap_ok    = (state == CAPTURE) && (glyph_ok || glyph_blank);
    idx_mask  = NUM_DIGITS'(1) << lat_idx;
    seen_upd  = seen | (cap_ok ? idx_mask : '0);
    frame_hit = cap_ok && ((seen & idx_mask) == '0) && (&seen_upd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_vals  <= '0;
      digit_valid <= '0;
`ifdef SEG7_BLANK_DETECT_EN
      digit_blank <= '0;
`endif
      seen        <= '0;
      frame_done  <= 1'b0;
      pattern_err <= 1'b0;
      select_err  <= 1'b0;
    end else begin
      frame_done  <= frame_hit;
      seen        <= frame_hit ? '0 : seen_upd;
      pattern_err <= (state == CAPTURE) && !glyph_ok && !glyph_blank;
      select_err  <= sel_err_next;
      if (cap_ok) begin
        digit_vals[lat_idx*4 +: 4] <= glyph_code;
        digit_valid[lat_idx]       <= !glyph_blank;
`ifdef SEG7_BLANK_DETECT_EN
        digit_blank[lat_idx]       <= glyph_blank;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder with default parameters (active-low buses).
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  trans = 7'h7F;
  logic [6:0]  led7seg = 7'h7F;
  logic [27:0] digit_vals;
  logic [6:0]  digit_valid;
`ifdef SEG7_BLANK_DETECT_EN
  logic [6:0]  digit_blank;
`endif
  logic        frame_done, pattern_err, select_err;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;
  int perr_cnt = 0;
  int serr_cnt = 0;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  seg7_scan_decoder #(
    .NUM_DIGITS(7),
    .SETTLE_CYCLES(4),
    .TRANS_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trans(trans),
    .led7seg(led7seg),
    .digit_vals(digit_vals),
    .digit_valid(digit_valid),
`ifdef SEG7_BLANK_DETECT_EN
    .digit_blank(digit_blank),
`endif
    .frame_done(frame_done),
    .pattern_err(pattern_err),
    .select_err(select_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done)  frame_cnt++;
    if (pattern_err) perr_cnt++;
    if (select_err)  serr_cnt++;
  end

  task automatic drive_raw(input logic [6:0] t, input logic [6:0] seg, input int cycles);
    trans   = t;
    led7seg = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic drive(input int d, input logic [6:0] seg, input int cycles);
    logic [6:0] one;
    one = 7'd1 << d;
    drive_raw(~one, seg, cycles);
  endtask

  task automatic bus_idle(input int cycles);
    drive_raw(7'h7F, 7'h7F, cycles);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_idle(3);
    rst = 1'b0;
    checks++; if (digit_vals !== 28'h0) begin errors++; $display("FAIL reset_vals: got %h want %h", digit_vals, 28'h0); end
    checks++; if (digit_valid !== 7'h00) begin errors++; $display("FAIL reset_valid: got %h want %h", digit_valid, 7'h00); end
    checks++; if ({frame_done, pattern_err, select_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want %b", {frame_done, pattern_err, select_err}, 3'b000); end
  endtask

  task automatic test_short_hold;
    drive(0, ~GLYPH[1], 3);
    bus_idle(10);
    checks++; if (digit_valid !== 7'h00) begin errors++; $display("FAIL short_hold_valid: got %h want %h", digit_valid, 7'h00); end
  endtask

  task automatic test_basic_capture;
    drive(0, 7'b1111001, 6);
    checks++; if (digit_valid[0] !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want %b", digit_valid[0], 1'b0); end
    @(negedge clk);
    checks++; if (digit_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want %b", digit_valid[0], 1'b1); end
    checks++; if (digit_vals[3:0] !== 4'h1) begin errors++; $display("FAIL basic_val: got %h want %h", digit_vals[3:0], 4'h1); end
    repeat (3) @(negedge clk);
    bus_idle(10);
    checks++; if (digit_vals !== 28'h0000001) begin errors++; $display("FAIL basic_all_vals: got %h want %h", digit_vals, 28'h0000001); end
    checks++; if (perr_cnt + serr_cnt !== 0) begin errors++; $display("FAIL basic_err_pulses: got %0d want %0d", perr_cnt + serr_cnt, 0); end
  endtask

  task automatic test_reset_mid_settle;
    drive(4, ~GLYPH[4], 3);
    rst = 1'b1;
    bus_idle(1);
    checks++; if (digit_vals !== 28'h0) begin errors++; $display("FAIL midrst_vals: got %h want %h", digit_vals, 28'h0); end
    checks++; if (digit_valid !== 7'h00) begin errors++; $display("FAIL midrst_valid: got %h want %h", digit_valid, 7'h00); end
    checks++; if ({frame_done, pattern_err, select_err} !== 3'b000) begin errors++; $display("FAIL midrst_pulses: got %b want %b", {frame_done, pattern_err, select_err}, 3'b000); end
    rst = 1'b0;
    bus_idle(12);
    checks++; if (digit_valid !== 7'h00) begin errors++; $display("FAIL midrst_no_capture: got %h want %h", digit_valid, 7'h00); end
  endtask

  task automatic test_full_scan;
    int base;
    base = frame_cnt;
    for (int k = 0; k < 7; k++) begin
      drive(k, ~GLYPH[k], 8);
      #1;
      checks++;
      if (frame_cnt !== base + ((k == 6) ? 1 : 0)) begin
        errors++; $display("FAIL scan_frame_d%0d: got %0d want %0d", k, frame_cnt - base, (k == 6) ? 1 : 0);
      end
    end
    bus_idle(5);
    checks++; if (digit_vals !== 28'h6543210) begin errors++; $display("FAIL scan_vals: got %h want %h", digit_vals, 28'h6543210); end
    checks++; if (digit_valid !== 7'h7F) begin errors++; $display("FAIL scan_valid: got %h want %h", digit_valid, 7'h7F); end
    for (int k = 0; k < 7; k++) drive(k, ~GLYPH[k], 8);
    bus_idle(5);
    checks++; if (frame_cnt !== base + 2) begin errors++; $display("FAIL scan_second_frame: got %0d want %0d", frame_cnt - base, 2); end
    checks++; if (perr_cnt + serr_cnt !== 0) begin errors++; $display("FAIL scan_err_pulses: got %0d want %0d", perr_cnt + serr_cnt, 0); end
  endtask

  task automatic test_ghost_bad_glyph;
    int sbase, pbase;
    sbase = serr_cnt;
    pbase = perr_cnt;
    drive_raw(7'b1111100, ~GLYPH[8], 10);
    checks++; if (serr_cnt !== sbase + 1) begin errors++; $display("FAIL ghost_select_err: got %0d want %0d", serr_cnt - sbase, 1); end
    checks++; if (digit_vals !== 28'h6543210) begin errors++; $display("FAIL ghost_vals: got %h want %h", digit_vals, 28'h6543210); end
    drive(2, 7'b0111111, 10);
    bus_idle(5);
    checks++; if (perr_cnt !== pbase + 1) begin errors++; $display("FAIL bad_glyph_pattern_err: got %0d want %0d", perr_cnt - pbase, 1); end
    checks++; if (digit_vals !== 28'h6543210) begin errors++; $display("FAIL bad_glyph_vals: got %h want %h", digit_vals, 28'h6543210); end
    checks++; if (serr_cnt !== sbase + 1) begin errors++; $display("FAIL bad_glyph_select_err: got %0d want %0d", serr_cnt - sbase, 1); end
  endtask

  task automatic test_blank;
    int pbase;
    pbase = perr_cnt;
    drive(3, 7'h7F, 10);
    bus_idle(5);
`ifdef SEG7_BLANK_DETECT_EN
    checks++; if (digit_blank !== 7'b0001000) begin errors++; $display("FAIL blank_flag: got %b want %b", digit_blank, 7'b0001000); end
    checks++; if (digit_valid !== 7'b1110111) begin errors++; $display("FAIL blank_valid: got %b want %b", digit_valid, 7'b1110111); end
    checks++; if (digit_vals !== 28'h6540210) begin errors++; $display("FAIL blank_vals: got %h want %h", digit_vals, 28'h6540210); end
`else
    checks++; if (perr_cnt !== pbase + 1) begin errors++; $display("FAIL blank_pattern_err: got %0d want %0d", perr_cnt - pbase, 1); end
    checks++; if (digit_vals !== 28'h6543210) begin errors++; $display("FAIL blank_vals: got %h want %h", digit_vals, 28'h6543210); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_short_hold();
    test_basic_capture();
    test_reset_mid_settle();
    test_full_scan();
    test_ghost_bad_glyph();
    test_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
